// File: rtl/anti_replay_pkg.sv
// Shared definitions for the anti-replay filter: register map offsets,
// STATUS bit positions and CTRL bit positions.
package anti_replay_pkg;

    // Register byte offsets (word aligned)
    localparam logic [4:0] ADDR_LAST_COUNTER  = 5'h00;
    localparam logic [4:0] ADDR_CHECK_COUNTER = 5'h04;
    localparam logic [4:0] ADDR_CHECK_NONCE   = 5'h08;
    localparam logic [4:0] ADDR_VALIDATE      = 5'h0C;
    localparam logic [4:0] ADDR_STATUS        = 5'h10;
    localparam logic [4:0] ADDR_CACHE_SIZE    = 5'h14;
    localparam logic [4:0] ADDR_CTRL          = 5'h18;
    localparam logic [4:0] ADDR_REJECT_COUNT  = 5'h1C;

    // STATUS bit positions
    localparam int STATUS_VALID       = 0;
    localparam int STATUS_REPLAY      = 1;
    localparam int STATUS_BAD_COUNTER = 2;
    localparam int STATUS_BAD_NONCE   = 3;

    // CTRL bit positions
    localparam int CTRL_CLEAR_CACHE = 0;
    localparam int CTRL_CLEAR_STATE = 1;

endpackage

// File: rtl/nonce_cache.sv
// Recent-nonce cache: DEPTH x 32-bit entries with valid bits, a parallel
// match against one lookup nonce, FIFO insertion and an occupancy count.
module nonce_cache #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     insert,
    input  logic [31:0]              insert_nonce,
    input  logic [31:0]              lookup_nonce,
    output logic                     match,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] wr_ptr;

    // Valid bits, write pointer and occupancy; the pointer wraps naturally
    // because DEPTH is a power of two, so a full cache overwrites the oldest.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid  <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (insert) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PTR_W'(1);
            if (count != FULL_COUNT) begin
                count <= count + (PTR_W + 1)'(1);
            end
        end
    end

    // Entry storage needs no reset since every read is qualified by valid.
    always_ff @(posedge clk) begin
        if (insert && !rst && !clear) begin
            entries[wr_ptr] <= insert_nonce;
        end
    end

    // Single-cycle compare of the lookup nonce against every valid entry.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i] == lookup_nonce)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/anti_replay_filter.sv
// Memory-mapped anti-replay checker. A packet is accepted only when its
// counter exceeds the last accepted counter and its nonce is not in the
// recent-nonce cache. Optional feature macro: ANTI_REPLAY_STATS_EN adds a
// saturating REJECT_COUNT register at offset 0x1C.
import anti_replay_pkg::*;

module anti_replay_filter #(
    parameter int CACHE_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(CACHE_DEPTH) + 1;

    logic [31:0]      last_counter;
    logic [31:0]      check_counter;
    logic [31:0]      check_nonce;
    logic [3:0]       status_reg;
    logic [3:0]       status_next;
    logic             cache_match;
    logic [CNT_W-1:0] cache_count;

    logic validate_fire;
    logic clear_cache;
    logic clear_state;
    logic counter_ok;
    logic nonce_ok;
    logic accept;

    assign validate_fire = we && (addr == ADDR_VALIDATE) && wdata[0];
    assign clear_cache   = we && (addr == ADDR_CTRL) && wdata[CTRL_CLEAR_CACHE];
    assign clear_state   = we && (addr == ADDR_CTRL) && wdata[CTRL_CLEAR_STATE];
    assign counter_ok    = check_counter > last_counter;
    assign nonce_ok      = !cache_match;
    assign accept        = validate_fire && counter_ok && nonce_ok;

    nonce_cache #(
        .DEPTH(CACHE_DEPTH)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_cache),
        .insert      (accept),
        .insert_nonce(check_nonce),
        .lookup_nonce(check_nonce),
        .match       (cache_match),
        .count       (cache_count)
    );

    // Status a validation would produce this cycle; rejects flag REPLAY plus each failed check.
    always_comb begin
        status_next = '0;
        if (counter_ok && nonce_ok) begin
            status_next[STATUS_VALID] = 1'b1;
        end else begin
            status_next[STATUS_REPLAY]      = 1'b1;
            status_next[STATUS_BAD_COUNTER] = !counter_ok;
            status_next[STATUS_BAD_NONCE]   = !nonce_ok;
        end
    end

    // Last accepted counter and status; only one register write can occur per cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_state) begin
            last_counter <= '0;
            status_reg   <= '0;
        end else if (we && (addr == ADDR_LAST_COUNTER)) begin
            last_counter <= wdata;
        end else if (validate_fire) begin
            status_reg <= status_next;
            if (accept) begin
                last_counter <= check_counter;
            end
        end
    end

    // Candidate counter and nonce registers written by firmware.
    always_ff @(posedge clk) begin
        if (rst) begin
            check_counter <= '0;
            check_nonce   <= '0;
        end else if (we) begin
            if (addr == ADDR_CHECK_COUNTER) check_counter <= wdata;
            if (addr == ADDR_CHECK_NONCE)   check_nonce   <= wdata;
        end
    end

`ifdef ANTI_REPLAY_STATS_EN
    logic [31:0] reject_count;
    logic        reject;

    assign reject = validate_fire && !(counter_ok && nonce_ok);

    // Saturating count of failed validations.
    always_ff @(posedge clk) begin
        if (rst || clear_state) begin
            reject_count <= '0;
        end else if (reject && (reject_count != '1)) begin
            reject_count <= reject_count + 32'd1;
        end
    end
`endif

    // Combinational register read; write-only, unmapped and unaligned offsets read 0.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_LAST_COUNTER:  rdata = last_counter;
            ADDR_CHECK_COUNTER: rdata = check_counter;
            ADDR_CHECK_NONCE:   rdata = check_nonce;
            ADDR_STATUS:        rdata = {28'b0, status_reg};
            ADDR_CACHE_SIZE:    rdata = 32'(cache_count);
`ifdef ANTI_REPLAY_STATS_EN
            ADDR_REJECT_COUNT:  rdata = reject_count;
`else
            ADDR_REJECT_COUNT:  rdata = '0;
`endif
            default:            rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_anti_replay_filter.sv
// Self-checking bench for anti_replay_filter: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_anti_replay_filter;

    localparam int DEPTH = 16;

    localparam logic [4:0] A_LAST  = 5'h00;
    localparam logic [4:0] A_CCNT  = 5'h04;
    localparam logic [4:0] A_CNON  = 5'h08;
    localparam logic [4:0] A_VAL   = 5'h0C;
    localparam logic [4:0] A_STAT  = 5'h10;
    localparam logic [4:0] A_SIZE  = 5'h14;
    localparam logic [4:0] A_CTRL  = 5'h18;
    localparam logic [4:0] A_REJ   = 5'h1C;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int total;
    int bad;

    // Reference model state
    logic [31:0] m_last;
    logic [31:0] m_ccnt;
    logic [31:0] m_cnon;
    logic [3:0]  m_status;
    logic [31:0] m_cache[$];
    logic [31:0] m_rej;

    anti_replay_filter #(.CACHE_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model of the accept/reject rule written directly from the register description.
    function automatic void model_validate();
        bit cok;
        bit nok;
        cok = m_ccnt > m_last;
        nok = 1'b1;
        foreach (m_cache[i]) if (m_cache[i] == m_cnon) nok = 1'b0;
        if (cok && nok) begin
            m_status = 4'h1;
            m_last   = m_ccnt;
            m_cache.push_back(m_cnon);
            if (m_cache.size() > DEPTH) void'(m_cache.pop_front());
        end else begin
            m_status = 4'h2 | (cok ? 4'h0 : 4'h4) | (nok ? 4'h0 : 4'h8);
            if (m_rej != 32'hFFFF_FFFF) m_rej++;
        end
    endfunction

    // One register write: driven after an edge, committed on the next rising edge.
    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        case (a)
            A_LAST: m_last = d;
            A_CCNT: m_ccnt = d;
            A_CNON: m_cnon = d;
            A_VAL:  if (d[0]) model_validate();
            A_CTRL: begin
                if (d[0]) m_cache.delete();
                if (d[1]) begin m_last = '0; m_status = '0; m_rej = '0; end
            end
            default: ;
        endcase
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_validate(input logic [31:0] c, input logic [31:0] n);
        applyStimulus(A_CCNT, c);
        applyStimulus(A_CNON, n);
        applyStimulus(A_VAL, 32'h1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_last = '0; m_ccnt = '0; m_cnon = '0; m_status = '0; m_rej = '0;
        m_cache.delete();
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4), d);
            total++;
            if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_off%0h got=%h want=0", i * 4, d); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        applyStimulus(A_CTRL, 32'h3);
        do_validate(32'd1, 32'hAAAA);
        rd(A_STAT, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL basic_accept_status got=%h want=1", d); end
        rd(A_LAST, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL basic_accept_last got=%h want=1", d); end
        rd(A_SIZE, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL basic_accept_size got=%h want=1", d); end
        do_validate(32'd1, 32'hAAAA);
        rd(A_STAT, d); total++; if (d !== 32'd14) begin bad++; $display("[TB] FAIL replay_status got=%h want=e", d); end
        rd(A_LAST, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL replay_last got=%h want=1", d); end
        do_validate(32'd0, 32'hBBBB);
        rd(A_STAT, d); total++; if (d !== 32'd6) begin bad++; $display("[TB] FAIL badcnt_status got=%h want=6", d); end
        rd(A_SIZE, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL badcnt_size got=%h want=1", d); end
        do_validate(32'd2, 32'hBBBB);
        rd(A_STAT, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL late_accept_status got=%h want=1", d); end
        rd(A_LAST, d); total++; if (d !== 32'h2) begin bad++; $display("[TB] FAIL late_accept_last got=%h want=2", d); end
        rd(A_SIZE, d); total++; if (d !== 32'h2) begin bad++; $display("[TB] FAIL late_accept_size got=%h want=2", d); end
    endtask

    task automatic test_eviction();
        logic [31:0] d;
        applyStimulus(A_CTRL, 32'h3);
        for (int i = 0; i <= DEPTH; i++) do_validate(32'(i + 1), 32'h5000 + 32'(i));
        rd(A_SIZE, d); total++; if (d !== 32'(DEPTH)) begin bad++; $display("[TB] FAIL evict_size got=%h want=%h", d, DEPTH); end
        do_validate(32'(DEPTH + 2), 32'h5000);
        rd(A_STAT, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL evict_reuse_status got=%h want=1", d); end
        do_validate(32'(DEPTH + 3), 32'h5001 + 32'(DEPTH - 1));
        rd(A_STAT, d); total++; if (d !== 32'd10) begin bad++; $display("[TB] FAIL evict_recent_status got=%h want=a", d); end
        rd(A_SIZE, d); total++; if (d !== 32'(DEPTH)) begin bad++; $display("[TB] FAIL evict_sat_size got=%h want=%h", d, DEPTH); end
    endtask

    task automatic test_max_counter();
        logic [31:0] d;
        applyStimulus(A_LAST, 32'hFFFF_FFFF);
        do_validate(32'd5, 32'h7777_0001);
        rd(A_STAT, d); total++; if (d !== 32'd6) begin bad++; $display("[TB] FAIL maxcnt_status got=%h want=6", d); end
        applyStimulus(A_CTRL, 32'h2);
        rd(A_STAT, d); total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL ctrl2_status got=%h want=0", d); end
        applyStimulus(A_VAL, 32'h1);
        rd(A_STAT, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL ctrl2_retry_status got=%h want=1", d); end
        rd(A_LAST, d); total++; if (d !== 32'd5) begin bad++; $display("[TB] FAIL ctrl2_retry_last got=%h want=5", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        applyStimulus(A_CTRL, 32'h3);
        applyStimulus(A_CCNT, 32'd9);
        applyStimulus(A_CNON, 32'h1234);
        applyStimulus(A_VAL, 32'h1);
        applyStimulus(A_VAL, 32'h1);
        rd(A_STAT, d); total++; if (d !== 32'd14) begin bad++; $display("[TB] FAIL b2b_status got=%h want=e", d); end
        rd(A_SIZE, d); total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL b2b_size got=%h want=1", d); end
        applyStimulus(A_CTRL, 32'h1);
        applyStimulus(A_VAL, 32'h1);
        rd(A_STAT, d); total++; if (d !== 32'd6) begin bad++; $display("[TB] FAIL ctrl1_status got=%h want=6", d); end
        rd(A_SIZE, d); total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL ctrl1_size got=%h want=0", d); end
    endtask

    task automatic test_register_map();
        logic [31:0] d;
        logic [31:0] exp_rej;
        applyStimulus(A_STAT, 32'hFFFF_FFFF);
        applyStimulus(A_SIZE, 32'hFFFF_FFFF);
        applyStimulus(A_VAL, 32'h2);
        rd(A_STAT, d); total++; if (d !== 32'(m_status)) begin bad++; $display("[TB] FAIL ro_status got=%h want=%h", d, m_status); end
        rd(A_SIZE, d); total++; if (d !== 32'(m_cache.size())) begin bad++; $display("[TB] FAIL ro_size got=%h want=%h", d, m_cache.size()); end
        rd(A_VAL, d); total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL validate_read got=%h want=0", d); end
        rd(A_CTRL, d); total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL ctrl_read got=%h want=0", d); end
        rd(5'h05, d); total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL unaligned_read got=%h want=0", d); end
`ifdef ANTI_REPLAY_STATS_EN
        exp_rej = m_rej;
`else
        exp_rej = 32'h0;
`endif
        rd(A_REJ, d); total++; if (d !== exp_rej) begin bad++; $display("[TB] FAIL reject_count got=%h want=%h", d, exp_rej); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] n;
        logic [31:0] exp_rej;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0:       c = m_last;
                1:       c = m_last - 32'($urandom_range(1, 3));
                2:       c = $urandom;
                default: c = m_last + 32'($urandom_range(1, 4));
            endcase
            n = 32'h9000 + 32'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) applyStimulus(A_CTRL, 32'($urandom_range(1, 3)));
            if ($urandom_range(0, 59) == 0) applyStimulus(A_LAST, $urandom);
            do_validate(c, n);
            rd(A_STAT, d); total++; if (d !== 32'(m_status)) begin bad++; $display("[TB] FAIL rand_status it=%0d got=%h want=%h", it, d, m_status); end
            rd(A_LAST, d); total++; if (d !== m_last) begin bad++; $display("[TB] FAIL rand_last it=%0d got=%h want=%h", it, d, m_last); end
            rd(A_SIZE, d); total++; if (d !== 32'(m_cache.size())) begin bad++; $display("[TB] FAIL rand_size it=%0d got=%h want=%h", it, d, m_cache.size()); end
`ifdef ANTI_REPLAY_STATS_EN
            exp_rej = m_rej;
`else
            exp_rej = 32'h0;
`endif
            rd(A_REJ, d); total++; if (d !== exp_rej) begin bad++; $display("[TB] FAIL rand_reject it=%0d got=%h want=%h", it, d, exp_rej); end
        end
    endtask

    // Scenario sequence
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_eviction();
        test_max_counter();
        test_back_to_back();
        test_register_map();
        test_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
